countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Down-counting companion to the program/event counters: loads a value, then
//  decrements by a programmable step each clock until it reaches zero, raising a
//  one-cycle expiry pulse and a sticky interrupt flag. Used as the core's
//  timer/watchdog source. Supports one-shot or periodic (auto-reload) operation.
// PARAMETERS
//  WIDTH      32   counter/load/step width in bits (unsigned arithmetic)
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  rst         in   1      reset; synchronous, active-high
//  load        in   1      capture load_value into count and reload register
//  load_value  in   WIDTH  value for load
//  step        in   WIDTH  decrement amount per running cycle
//  periodic    in   1      1 = auto-reload on expiry, 0 = one-shot
//  start       in   1      begin counting (IDLE/DONE -> RUN)
//  stop        in   1      halt counting (RUN -> IDLE), count held
//  irq_ack     in   1      clears irq
//  count       out  WIDTH  current counter value
//  busy        out  1      1 while in RUN
//  expired     out  1      one-cycle pulse on the cycle after reaching zero
//  irq         out  1      sticky expiry flag
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, count=0, reload=0, busy=0,
//    expired=0, irq=0. Reset mid-RUN aborts with no expiry pulse.
//  - States: IDLE, RUN, DONE. busy = (state==RUN). All outputs registered.
//  - Priority per edge: rst > load > stop > start > decrement.
//  - load: count<=load_value, reload<=load_value; state unchanged (load in RUN
//    restarts the countdown from the new value, no expiry that cycle).
//  - stop in RUN: -> IDLE, count held. stop in IDLE/DONE: no effect.
//  - start in IDLE or DONE: -> RUN. start in RUN: ignored. If count==0 at
//    start, first RUN cycle expires immediately (see decrement rule).
//  - Decrement, each edge in RUN with no higher-priority event:
//    * count > step: count <= count - step.
//    * count <= step (unsigned, incl. count==0): expiry; count saturates, never
//      wraps. On expiry expired<=1 for exactly one cycle, irq<=1.
//      periodic=1 and reload!=0: count<=reload, stay RUN.
//      periodic=0 or reload==0: count<=0, -> DONE.
//    * step==0 with count!=0: count holds, stays RUN, no expiry.
//  - Latency: start sampled at edge E0, load L, step 1 -> count reaches 1 after
//    E0+(L-1), expired high in the cycle after edge E0+L.
//  - irq: set on expiry edge; cleared by irq_ack; expiry and irq_ack on same
//    edge -> irq stays 1 (set wins). expired is not affected by irq_ack.
//  - periodic sampled at the expiry edge only.
// TESTING
//  1. rst=1 one edge during RUN with count=7 -> count=0, busy=0, irq=0,
//     no expired pulse.
//  2. load 5, step 1, periodic 0, start -> count 4,3,2,1 on successive edges,
//     then count=0, expired pulse 1 cycle, irq=1, state DONE, busy=0.
//  3. load 10, step 4, periodic 1, start -> 6,2, then expiry with count=10,
//     busy stays 1, expired every 3rd cycle thereafter.
//  4. load 9, step 0, start -> count holds 9, no expiry over 20 cycles; stop
//     -> busy=0, count=9; start with step 3 -> 6,3,expiry.
//  5. expiry edge coincident with irq_ack=1 -> irq=1; irq_ack next edge -> 0.
//  6. RUN count=3, load 100 and stop same edge -> count=100, state RUN (load
//     wins, stop ignored); start with count=0 -> expiry on first RUN edge.

Source files
------------

// File: rtl/countdown_timer.sv
// Programmable down-counter with step decrement, one-shot/periodic reload,
// single-cycle expiry pulse and sticky interrupt flag.
module countdown_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] step,
    input  logic             periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nx;
    logic [WIDTH-1:0] count_nx;
    logic             expire_nx;

    // Priority chain: load > stop > start > decrement. An asserted stop
    // consumes the cycle even when it has nothing to halt.
    always_comb begin
        state_nx  = state;
        count_nx  = count;
        reload_nx = reload;
        expire_nx = 1'b0;
        if (load) begin
            count_nx  = load_value;
            reload_nx = load_value;
        end else if (stop) begin
            if (state == RUN) begin
                state_nx = IDLE;
            end
        end else if (start && (state != RUN)) begin
            state_nx = RUN;
        end else if (state == RUN) begin
            if (count > step) begin
                count_nx = count - step;
            end else begin
                // Saturating expiry: covers count==0 and count<=step.
                expire_nx = 1'b1;
                if (periodic && (reload != '0)) begin
                    count_nx = reload;
                end else begin
                    count_nx = '0;
                    state_nx = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            busy    <= 1'b0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            reload  <= reload_nx;
            busy    <= (state_nx == RUN);
            expired <= expire_nx;
            irq     <= expire_nx | (irq & ~irq_ack);
        end
    end

endmodule
